// File: rtl/serial_tx_pkg.sv
// Shared state encoding, parity mode constants and parity helper for the
// serial transmitter.
package serial_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // Upper bits of the word are zero-extended, so they never affect the XOR.
    function automatic logic parity_bit(input logic [8:0] word, input int mode);
        return (mode == PARITY_ODD) ? ~^word : ^word;
    endfunction

endpackage

// File: rtl/tx_fifo.sv
// Synchronous FIFO with first-word-fall-through read so the transmitter can
// load its shift register on the same edge it pops.
module tx_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_full,
    output logic              o_empty,
    output logic [CNT_W-1:0]  o_count
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_push;
    logic              w_pop;

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop && !w_push) r_count <= r_count - 1'b1;
        end
    end

endmodule

// File: rtl/serial_transmitter.sv
// Parametrised UART-style transmitter: buffered parallel input, framed serial
// output with optional parity and one or two stop bits.
module serial_transmitter
    import serial_tx_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DATA_W-1:0]               bus,
    input  logic                            bus_valid,
    output logic                            bus_ready,
    output logic                            data,
    output logic                            busy,
    output logic                            frame_done,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_W);

    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("serial_transmitter: STOP_BITS must be 1 or 2");
    end

    tx_state_t           r_state, w_state_next;
    logic [BAUD_W-1:0]   r_baud_cnt, w_baud_next;
    logic [BIT_W-1:0]    r_bit_cnt, w_bit_next;
    logic [DATA_W-1:0]   r_shift, w_shift_next;
    logic                r_parity, w_parity_next;
    logic                r_data, w_data_next;
    logic                r_busy, w_busy_next;
    logic                r_frame_done, w_frame_done_next;

    logic [DATA_W-1:0]   w_fifo_rdata;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic                w_bit_end;
    logic                w_last_data;
    logic                w_frame_end;
    logic                w_pop;

    tx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (bus_valid && bus_ready),
        .i_wdata (bus),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (fifo_count)
    );

    assign w_bit_end   = (r_baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
    assign w_last_data = (r_bit_cnt == BIT_W'(DATA_W - 1));
    assign w_frame_end = (r_state == ST_STOP) && w_bit_end && (r_bit_cnt == BIT_W'(STOP_BITS - 1));
    // Popping at the end of the stop bit gives zero-gap back-to-back frames.
    assign w_pop       = !w_fifo_empty && ((r_state == ST_IDLE) || w_frame_end);

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (!w_fifo_empty) w_state_next = ST_START;
            ST_START:  if (w_bit_end) w_state_next = ST_DATA;
            ST_DATA:   if (w_bit_end && w_last_data)
                           w_state_next = (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
            ST_PARITY: if (w_bit_end) w_state_next = ST_STOP;
            ST_STOP:   if (w_frame_end) w_state_next = w_fifo_empty ? ST_IDLE : ST_START;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_baud_next   = (r_state == ST_IDLE || w_bit_end) ? '0 : r_baud_cnt + 1'b1;
        w_bit_next    = r_bit_cnt;
        w_shift_next  = r_shift;
        w_parity_next = r_parity;
        if (w_state_next != r_state) begin
            w_bit_next = '0;
        end else if (w_bit_end && (r_state == ST_DATA || r_state == ST_STOP)) begin
            w_bit_next = r_bit_cnt + 1'b1;
        end
        if (w_pop) begin
            w_shift_next  = w_fifo_rdata;
            w_parity_next = parity_bit(9'(w_fifo_rdata), PARITY_MODE);
        end else if (r_state == ST_DATA && w_bit_end) begin
            w_shift_next = r_shift >> 1;
        end
    end

    // Outputs are computed from next-state values so every pin is a flop.
    always_comb begin
        w_busy_next       = (w_state_next != ST_IDLE);
        w_frame_done_next = (w_state_next == ST_STOP)
                         && (w_baud_next == BAUD_W'(CLKS_PER_BIT - 1))
                         && (w_bit_next == BIT_W'(STOP_BITS - 1));
        case (w_state_next)
            ST_START:  w_data_next = 1'b0;
            ST_DATA:   w_data_next = w_shift_next[0];
            ST_PARITY: w_data_next = w_parity_next;
            default:   w_data_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_baud_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_parity     <= 1'b0;
            r_data       <= 1'b1;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_baud_cnt   <= w_baud_next;
            r_bit_cnt    <= w_bit_next;
            r_shift      <= w_shift_next;
            r_parity     <= w_parity_next;
            r_data       <= w_data_next;
            r_busy       <= w_busy_next;
            r_frame_done <= w_frame_done_next;
        end
    end

    assign bus_ready  = !w_fifo_full;
    assign data       = r_data;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

endmodule
